// File: rtl/run_seq_pkg.sv
// Shared types and default constants for the run sequencer.
// Holds the FSM state enum and parameter defaults.
package run_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_ARM,
    S_RUN,
    S_REPORT,
    S_FINISH
  } state_e;

  localparam int DEF_NUM_PROGS = 3;
  localparam int DEF_START_LEN = 2;
  localparam int DEF_CW        = 16;
  localparam int DEF_TIMEOUT   = 'hFFFF;

endpackage

// File: rtl/run_sequencer_cycle_timer.sv
// Saturating cycle counter used to time each program.
// Clear wins over enable; the count sticks once it equals limit.
module cycle_timer
  import run_seq_pkg::*;
#(
  parameter int CW = DEF_CW
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          clear,
  input  logic          enable,
  input  logic [CW-1:0] limit,
  output logic [CW-1:0] count,
  output logic          at_limit
);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != limit)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count    = count_q;
  assign at_limit = (count_q == limit);

endmodule

// File: rtl/run_sequencer.sv
// Launches a batch of programs on a processor and measures
// how many cycles each one takes, with a per-program timeout.
module run_sequencer
  import run_seq_pkg::*;
#(
  parameter int NUM_PROGS = DEF_NUM_PROGS,
  parameter int START_LEN = DEF_START_LEN,
  parameter int CW        = DEF_CW,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Go,
  input  logic          Done,
  output logic          Start,
  output logic [1:0]    ProgIdx,
  output logic          Busy,
  output logic          AllDone,
  output logic [CW-1:0] CycleCount,
  output logic          CountValid,
  output logic          TimedOut
);

  localparam int SW = (START_LEN > 1) ? $clog2(START_LEN) : 1;
  localparam logic [SW-1:0] SLEN_LAST = SW'(START_LEN - 1);
  localparam logic [1:0]    LAST_PROG = 2'(NUM_PROGS - 1);
  localparam logic [CW-1:0] LIMIT     = CW'(TIMEOUT);

  state_e        state_q, state_d;
  logic [SW-1:0] slen_q, slen_d;

  logic          start_q, start_d;
  logic [1:0]    prog_q, prog_d;
  logic          busy_q, busy_d;
  logic          alldone_q, alldone_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          cv_q, cv_d;
  logic          to_q, to_d;

  logic [CW-1:0] count;
  logic          at_limit;
  logic          timer_clr, timer_en;
  logic          go_ok, time_out, prog_done;

  assign timer_clr = (state_q == S_START);
  assign timer_en  = (state_q == S_ARM) || (state_q == S_RUN);

  cycle_timer #(
    .CW(CW)
  ) u_timer (
    .Clk     (Clk),
    .Reset   (Reset),
    .clear   (timer_clr),
    .enable  (timer_en),
    .limit   (LIMIT),
    .count   (count),
    .at_limit(at_limit)
  );

  assign go_ok     = Go && ((state_q == S_IDLE) ||
                            (state_q == S_FINISH));
  assign time_out  = timer_en && at_limit;
  assign prog_done = (state_q == S_RUN) && Done && !at_limit;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      slen_q  <= '0;
    end else begin
      state_q <= state_d;
      slen_q  <= slen_d;
    end
  end

  always_comb begin
    state_d = state_q;
    slen_d  = '0;
    unique case (state_q)
      S_IDLE, S_FINISH: begin
        if (Go) state_d = S_START;
      end
      S_START: begin
        slen_d = slen_q + 1'b1;
        if (slen_q == SLEN_LAST) state_d = S_ARM;
      end
      // Stale Done from the previous program must clear first.
      S_ARM: begin
        if (at_limit)   state_d = S_FINISH;
        else if (!Done) state_d = S_RUN;
      end
      S_RUN: begin
        if (at_limit)  state_d = S_FINISH;
        else if (Done) state_d = S_REPORT;
      end
      S_REPORT: begin
        state_d = (prog_q == LAST_PROG) ? S_FINISH : S_START;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    start_d   = (state_d == S_START);
    busy_d    = !((state_d == S_IDLE) || (state_d == S_FINISH));
    alldone_d = (state_d == S_FINISH);
    cv_d      = time_out || prog_done;
    prog_d    = prog_q;
    to_d      = to_q;
    cnt_d     = cnt_q;
    if (go_ok) begin
      prog_d = '0;
      to_d   = 1'b0;
    end else if ((state_q == S_REPORT) && (state_d == S_START)) begin
      prog_d = prog_q + 2'd1;
    end
    if (time_out) begin
      to_d  = 1'b1;
      cnt_d = LIMIT;
    end else if (prog_done) begin
      cnt_d = count;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      start_q   <= 1'b0;
      prog_q    <= '0;
      busy_q    <= 1'b0;
      alldone_q <= 1'b0;
      cnt_q     <= '0;
      cv_q      <= 1'b0;
      to_q      <= 1'b0;
    end else begin
      start_q   <= start_d;
      prog_q    <= prog_d;
      busy_q    <= busy_d;
      alldone_q <= alldone_d;
      cnt_q     <= cnt_d;
      cv_q      <= cv_d;
      to_q      <= to_d;
    end
  end

  assign Start      = start_q;
  assign ProgIdx    = prog_q;
  assign Busy       = busy_q;
  assign AllDone    = alldone_q;
  assign CycleCount = cnt_q;
  assign CountValid = cv_q;
  assign TimedOut   = to_q;

endmodule

// File: doc/run_sequencer.md
RUN_SEQUENCER -- requirements
Module: run_sequencer

Interface
REQ-001 Parameter NUM_PROGS, default 3: number of programs launched per batch; legal range 1..4.
REQ-002 Parameter START_LEN, default 2: cycles Start is held high per launch; minimum 1.
REQ-003 Parameter CW, default 16: width of the cycle counter and of CycleCount.
REQ-004 Parameter TIMEOUT, default 16'hFFFF: per-program cycle limit; must be less than 2^CW.
REQ-005 Clk  in  1  clock; all state changes on posedge.
REQ-006 Reset  in  1  synchronous, active-high.
REQ-007 Go  in  1  batch request; sampled only in IDLE or FINISH.
REQ-008 Done  in  1  processor level "program finished"; held high until the next Start.
REQ-009 Start  out  1  processor launch strobe; the processor's program counter holds while Start is high and jumps to the next entry point when Start falls.
REQ-010 ProgIdx  out  2  index of the current or last program, 0..NUM_PROGS-1.
REQ-011 Busy  out  1  high in every state except IDLE and FINISH.
REQ-012 AllDone  out  1  high in FINISH.
REQ-013 CycleCount  out  CW  measured length of the most recent program.
REQ-014 CountValid  out  1  one-cycle pulse; CycleCount is updated on the same cycle.
REQ-015 TimedOut  out  1  sticky error flag.

Function
REQ-016 The FSM shall have the states IDLE, START, ARM, RUN, REPORT and FINISH; all outputs shall be registered.
REQ-017 IDLE/FINISH + Go=1 -> START, with ProgIdx=0 and TimedOut and AllDone cleared; Go in any other state shall be ignored.
REQ-018 START: Start=1 for exactly START_LEN consecutive cycles, then -> ARM with Start=0 and the counter cleared to 0.
REQ-019 ARM: wait for Done=0 (the previous program's Done clearing), then -> RUN; the counter increments every ARM cycle.
REQ-020 RUN: the counter increments every cycle; on Done=1, latch CycleCount = counter value at that edge, pulse CountValid, and -> REPORT.
REQ-021 Counter semantics: the counter holds 0 on the first ARM cycle, so CycleCount = cycles from ARM entry to the edge where Done is sampled high.
REQ-022 REPORT (1 cycle): if ProgIdx == NUM_PROGS-1 -> FINISH; otherwise increment ProgIdx and -> START.
REQ-023 Timeout: if the counter reaches TIMEOUT in ARM or RUN, then set TimedOut, set CycleCount=TIMEOUT, pulse CountValid, and -> FINISH, abandoning the remaining programs.
REQ-024 The counter shall saturate at TIMEOUT and never wrap.
REQ-025 Done=1 on the first ARM cycle shall not complete the program; the FSM shall stay in ARM until Done is sampled 0.
REQ-026 FINISH: AllDone=1, Start=0; ProgIdx, CycleCount and TimedOut shall hold until Go or Reset.
REQ-027 Go and Done=1 on the same cycle in FINISH: Go wins and the new batch starts.
REQ-028 NUM_PROGS=1 shall give exactly one START/ARM/RUN/REPORT pass before FINISH.

Reset
REQ-029 While Reset is high, and at the first edge after it: state=IDLE; Start=0, ProgIdx=0, Busy=0, AllDone=0, CycleCount=0, CountValid=0, TimedOut=0, counter=0.
REQ-030 Reset asserted mid-batch, including during START, shall drop Start on the next edge.
REQ-031 A batch interrupted by Reset shall not resume; a fresh Go is required.

Structure
REQ-032 Package run_seq_pkg shall hold the state enum typedef and the default parameter constants.
REQ-033 The saturating counter shall be one sub-module, cycle_timer, with inputs clear, enable and limit, and outputs count and at_limit.
REQ-034 All other logic shall be flat within run_sequencer; target size 150-250 lines.

Verification
REQ-035 Reset, then Go pulse, Done low 0..9 and high from cycle 10 after ARM entry -> Start high 2 cycles, CountValid with CycleCount=10, ProgIdx 0 -> 1.
REQ-036 Three programs with Done at 10, 4 and 25 cycles -> three CountValid pulses with 10, 4, 25; AllDone=1 with ProgIdx=2; Busy=0 after FINISH.
REQ-037 Done held high from the prior program for 3 ARM cycles, then low, then high 5 cycles later -> the stale Done is ignored and CycleCount=8.
REQ-038 TIMEOUT=20 and Done never rises -> CountValid with CycleCount=20, TimedOut=1, AllDone=1, ProgIdx=0.
REQ-039 Reset asserted on the second START cycle of program 1 -> next edge Start=0, ProgIdx=0, Busy=0; Go pulses issued mid-RUN are ignored.
